spi_reg_ctrl: RTL and testbench
===============================

Name: spi_reg_ctrl

Overview:
SPI-slave transaction controller that sequences the register map.
- Deserialises SPI mode-0 frames.
- Drives the register read-mux address and shifts the muxed read data out on MISO.
- Issues single-cycle write strobes toward the writable registers (gate, dac, pwm, counter config).
- Sits between the external SPI pins and the register-select / register-write logic; the whole block runs in the system clock domain.

Parameters:
SYNC_STAGES, 2, synchroniser depth for spi_sclk / spi_cs_n / spi_mosi (min 2)
AUTO_INC, 1, 1 = address increments after every data byte in a frame; 0 = address held
CMD_WR, 8'h01, command byte value selecting a write frame
CMD_RD, 8'h00, command byte value selecting a read frame

Ports:
clk  in  1  system clock; must be ≥8× SCLK frequency
rst  in  1  asynchronous, active-high reset
spi_sclk  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0)
spi_cs_n  in  1  SPI chip select, active low
spi_mosi  in  1  SPI data in, MSB first
spi_miso  out  1  SPI data out, MSB first; 0 when not in a read data phase
addr  out  8  address to the register read mux
data_in  in  8  combinational read data returned by the register mux for addr
wr_addr  out  8  write address, valid while wr_stb=1
wr_data  out  8  write data, valid while wr_stb=1
wr_stb  out  1  one-clk write strobe
busy  out  1  1 while a frame is open (CS asserted, state != IDLE)
frame_err  out  1  one-clk pulse on a truncated byte or unknown command

Behaviour:
- Reset (async, rst=1): state IDLE, bit counter 0, shift registers 0; addr, wr_addr, wr_data = 8'h00; wr_stb, busy, frame_err, spi_miso = 0. Synchroniser flops reset to idle levels: sclk=0, cs_n=1, mosi=0.
- Inputs pass through SYNC_STAGES flops. One further registered stage produces sclk_rise, sclk_fall, cs_fall and cs_rise pulses.
- RX: on sclk_rise, shift mosi into rx_sr LSB and increment the 3-bit bit counter. The 8th rise (counter wraps 7→0) is a byte-complete event.
- Frame format: [command byte] [address byte] [data byte]* (any number of data bytes).
- FSM states:
  - IDLE: on cs_fall → CMD, bit counter cleared.
  - CMD: on byte complete, rx==CMD_WR → ADDR_WR; rx==CMD_RD → ADDR_RD; otherwise → IGNORE with a frame_err pulse.
  - ADDR_WR: on byte complete, addr<=rx → DATA_WR.
  - ADDR_RD: on byte complete, addr<=rx → DATA_RD.
  - DATA_WR: on each byte complete, register wr_addr<=addr and wr_data<=rx, assert wr_stb for exactly 1 clk (the clk after the byte-complete event), and in the same clk addr<=addr+1 when AUTO_INC=1.
  - DATA_RD: on each byte complete, addr<=addr+1 when AUTO_INC=1.
  - IGNORE: consume clocks; no strobes, miso=0.
- Read shifting: in ADDR_RD and DATA_RD, the sclk_fall that follows a byte-complete event loads tx_sr<=data_in; every other sclk_fall in DATA_RD shifts tx_sr left. spi_miso = tx_sr[7] in DATA_RD, else 0. The first data byte of a read frame therefore returns the register at the sent address; later bytes return addr+1, addr+2, …
- Address arithmetic is 8-bit modulo: 8'hFF+1 = 8'h00, with no flag.
- Write latency: wr_stb rises SYNC_STAGES+2 clk after the 8th SCLK rising edge at the pin.
- cs_rise in any state → IDLE in the next clk, spi_miso=0, addr held. If the bit counter ≠ 0 at cs_rise, the partial byte is discarded, no wr_stb is issued, and frame_err pulses 1 clk.
- cs_rise and sclk_rise in the same clk: cs_rise wins and the edge is ignored.
- wr_stb never asserts for two consecutive clks, and never outside DATA_WR.
- busy = (state != IDLE).
- rst asserted mid-frame: immediate return to reset values. The next frame must begin with a fresh cs_fall; a frame already in progress when rst deasserts is ignored until CS deasserts.

Test Plan:
- Write frame 01 20 A5 → one wr_stb, wr_addr=8'h20, wr_data=8'hA5; addr=8'h21 afterwards; frame_err=0.
- Burst write 01 FF 11 22 (AUTO_INC=1) → wr_stb twice: (8'hFF, 8'h11) then (8'h00, 8'h22), confirming wrap-around.
- Read frame 00 00 xx xx, data_in=8'h13 at addr 0 and 8'h00 at addr 1 → MISO bytes 8'h13 then 8'h00; spi_miso=0 during the command and address bytes.
- Write frame 01 36 with CS raised after 5 data bits → no wr_stb, one frame_err pulse, busy=0 within SYNC_STAGES+2 clk.
- Command byte 7E followed by 2 bytes → frame_err pulse after byte 1, no wr_stb, spi_miso=0 for the whole frame.
- rst pulsed during the data byte of a write frame → all outputs 0; a following 01 23 5A frame → wr_stb with (8'h23, 8'h5A).

Source files
------------

// File: rtl/spi_reg_ctrl.sv
// SPI mode-0 slave that sequences the register map: command / address / data bytes,
// read-mux addressing with MISO shift-out, and single-cycle write strobes.
module spi_reg_ctrl #(
    parameter int         SYNC_STAGES = 2,
    parameter bit         AUTO_INC    = 1'b1,
    parameter logic [7:0] CMD_WR      = 8'h01,
    parameter logic [7:0] CMD_RD      = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_sclk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic [7:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       wr_stb,
    output logic       busy,
    output logic       frame_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR_WR, S_ADDR_RD, S_DATA_WR, S_DATA_RD, S_IGNORE
    } state_t;

    state_t r_state, w_state_nxt;

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
    logic [SYNC_STAGES:0]   r_settle;
    logic       r_sclk_d, r_cs_d, r_mosi_d, r_armed;
    logic       r_sclk_rise, r_sclk_fall, r_cs_fall, r_cs_rise;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_rx_sr, r_tx_sr, r_addr, r_wr_addr, r_wr_data;
    logic       r_wr_stb, r_frame_err, r_load_pend;

    logic       w_sclk, w_cs_n, w_mosi, w_byte_done, w_err_nxt;
    logic [7:0] w_rx_byte;

    assign w_sclk    = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_n    = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];
    assign w_rx_byte = {r_rx_sr[6:0], r_mosi_d};
    assign w_byte_done = r_sclk_rise && !r_cs_rise && (r_state != S_IDLE) && (r_bit_cnt == 3'd7);

    // Synchronisers plus the registered edge-detect stage. r_armed stays low after reset
    // until CS is seen idle, so a frame already open at reset release is never decoded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_settle    <= '0;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
            r_mosi_d    <= 1'b0;
            r_armed     <= 1'b0;
            r_sclk_rise <= 1'b0;
            r_sclk_fall <= 1'b0;
            r_cs_fall   <= 1'b0;
            r_cs_rise   <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            r_settle    <= {r_settle[SYNC_STAGES-1:0], 1'b1};
            r_sclk_d    <= w_sclk;
            r_cs_d      <= w_cs_n;
            r_mosi_d    <= w_mosi;
            if (r_settle[SYNC_STAGES] && w_cs_n && r_cs_d)
                r_armed <= 1'b1;
            r_sclk_rise <= w_sclk & ~r_sclk_d;
            r_sclk_fall <= ~w_sclk & r_sclk_d;
            r_cs_fall   <= r_armed & r_cs_d & ~w_cs_n;
            r_cs_rise   <= w_cs_n & ~r_cs_d;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = 1'b0;
        if (r_cs_rise) begin
            w_state_nxt = S_IDLE;
            w_err_nxt   = (r_state != S_IDLE) && (r_bit_cnt != 3'd0);
        end else begin
            case (r_state)
                S_IDLE:    if (r_cs_fall) w_state_nxt = S_CMD;
                S_CMD: begin
                    if (w_byte_done) begin
                        if (w_rx_byte == CMD_WR)      w_state_nxt = S_ADDR_WR;
                        else if (w_rx_byte == CMD_RD) w_state_nxt = S_ADDR_RD;
                        else begin
                            w_state_nxt = S_IGNORE;
                            w_err_nxt   = 1'b1;
                        end
                    end
                end
                S_ADDR_WR: if (w_byte_done) w_state_nxt = S_DATA_WR;
                S_ADDR_RD: if (w_byte_done) w_state_nxt = S_DATA_RD;
                default:   w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt   <= 3'd0;
            r_rx_sr     <= 8'h00;
            r_tx_sr     <= 8'h00;
            r_addr      <= 8'h00;
            r_wr_addr   <= 8'h00;
            r_wr_data   <= 8'h00;
            r_wr_stb    <= 1'b0;
            r_frame_err <= 1'b0;
            r_load_pend <= 1'b0;
        end else begin
            r_frame_err <= w_err_nxt;
            r_wr_stb    <= w_byte_done && (r_state == S_DATA_WR);

            if (r_state == S_IDLE || r_cs_rise) begin
                r_bit_cnt <= 3'd0;
            end else if (r_sclk_rise) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                r_rx_sr   <= w_rx_byte;
            end

            if (w_byte_done) begin
                case (r_state)
                    S_ADDR_WR, S_ADDR_RD: r_addr <= w_rx_byte;
                    S_DATA_WR, S_DATA_RD: if (AUTO_INC) r_addr <= r_addr + 8'd1;
                    default: ;
                endcase
                if (r_state == S_DATA_WR) begin
                    r_wr_addr <= r_addr;
                    r_wr_data <= w_rx_byte;
                end
            end

            // data_in is sampled on the falling edge after each byte, once addr has settled
            if (r_state == S_IDLE || r_cs_rise)
                r_load_pend <= 1'b0;
            else if (w_byte_done && (r_state == S_ADDR_RD || r_state == S_DATA_RD))
                r_load_pend <= 1'b1;
            else if (r_sclk_fall)
                r_load_pend <= 1'b0;

            if (r_sclk_fall && r_load_pend)
                r_tx_sr <= data_in;
            else if (r_sclk_fall && r_state == S_DATA_RD)
                r_tx_sr <= {r_tx_sr[6:0], 1'b0};
        end
    end

    assign spi_miso  = (r_state == S_DATA_RD) ? r_tx_sr[7] : 1'b0;
    assign addr      = r_addr;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign wr_stb    = r_wr_stb;
    assign busy      = (r_state != S_IDLE);
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: bit-banged SPI master, register-file model behind
// data_in, and a write-strobe scoreboard compared against hand-computed expectations.
module tb_spi_reg_ctrl;
  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic spi_sclk = 1'b0;
  logic spi_cs_n = 1'b1;
  logic spi_mosi = 1'b0;
  logic spi_miso;
  logic [7:0] addr, data_in, wr_addr, wr_data;
  logic wr_stb, busy, frame_err;

  logic [7:0] mem [256];
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int n_tests = 0;
  int n_fail = 0;
  int n_ferr = 0;
  int n_dbl = 0;
  logic prev_stb = 1'b0;
  logic [7:0] rx;

  assign data_in = mem[addr];

  spi_reg_ctrl dut (
    .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .addr(addr), .data_in(data_in),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_stb(wr_stb), .busy(busy),
    .frame_err(frame_err)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // write-strobe and frame_err monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_stb) begin
        got_q.push_back({wr_addr, wr_data});
        if (prev_stb) n_dbl++;
      end
      if (frame_err) n_ferr++;
    end
    prev_stb = wr_stb;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_stb(input string tag);
    logic [15:0] g, e;
    check({tag, " stb count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check({tag, " stb addr/data"}, g, e);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // driver tasks
  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] r);
    r = 8'h00;
    for (int i = 0; i < n; i++) begin
      spi_mosi = tx[7-i];
      repeat (HALF) @(negedge clk);
      r[7-i] = spi_miso;
      spi_sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] r);
    spi_bits(tx, 8, r);
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (2*HALF + 4) @(negedge clk);
  endtask

  initial begin
    int ferr0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA0;
    mem[0] = 8'h13;
    mem[1] = 8'h00;
    mem[2] = 8'hC3;

    // reset state
    repeat (3) @(negedge clk);
    check("reset outputs", {addr, wr_addr, wr_data, wr_stb, busy, frame_err, spi_miso}, 32'h0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // single write 01 20 A5
    cs_low();
    check("busy in frame", busy, 1'b1);
    spi_byte(8'h01, rx);
    spi_byte(8'h20, rx);
    spi_byte(8'hA5, rx);
    cs_high();
    exp_q.push_back(16'h20A5);
    check_stb("write");
    check("write addr after", addr, 8'h21);
    check("write frame_err", n_ferr, 0);
    check("busy after write", busy, 1'b0);

    // burst write with address wrap
    cs_low();
    spi_byte(8'h01, rx);
    spi_byte(8'hFF, rx);
    spi_byte(8'h11, rx);
    spi_byte(8'h22, rx);
    cs_high();
    exp_q.push_back(16'hFF11);
    exp_q.push_back(16'h0022);
    check_stb("burst");
    check("burst addr after", addr, 8'h01);

    // read frame 00 00 xx xx xx
    cs_low();
    spi_byte(8'h00, rx);
    check("read miso cmd", rx, 8'h00);
    spi_byte(8'h00, rx);
    check("read miso addr", rx, 8'h00);
    spi_byte(8'hFF, rx);
    check("read byte0", rx, 8'h13);
    spi_byte(8'hFF, rx);
    check("read byte1", rx, 8'h00);
    spi_byte(8'h00, rx);
    check("read byte2", rx, 8'hC3);
    cs_high();
    check_stb("read");
    check("read addr after", addr, 8'h03);
    check("read frame_err", n_ferr, 0);

    // truncated write: CS raised after 5 data bits
    cs_low();
    spi_byte(8'h01, rx);
    spi_byte(8'h36, rx);
    spi_bits(8'hF0, 5, rx);
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (4) @(negedge clk);
    check("trunc busy low", busy, 1'b0);
    repeat (2*HALF) @(negedge clk);
    check("trunc frame_err", n_ferr, 1);
    check_stb("trunc");
    check("trunc addr", addr, 8'h36);

    // unknown command 7E
    ferr0 = n_ferr;
    cs_low();
    spi_byte(8'h7E, rx);
    check("badcmd miso0", rx, 8'h00);
    check("badcmd frame_err", n_ferr - ferr0, 1);
    spi_byte(8'h01, rx);
    check("badcmd miso1", rx, 8'h00);
    spi_byte(8'hAA, rx);
    check("badcmd miso2", rx, 8'h00);
    cs_high();
    check("badcmd frame_err end", n_ferr - ferr0, 1);
    check_stb("badcmd");

    // reset in the middle of a write data byte
    ferr0 = n_ferr;
    cs_low();
    spi_byte(8'h01, rx);
    spi_byte(8'h40, rx);
    spi_bits(8'h9C, 4, rx);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst outputs", {addr, wr_addr, wr_data, wr_stb, busy, frame_err, spi_miso}, 32'h0);
    rst = 1'b0;
    spi_bits(8'hC0, 4, rx);
    spi_byte(8'h77, rx);
    check("midrst ignored busy", busy, 1'b0);
    cs_high();
    check_stb("midrst");
    check("midrst frame_err", n_ferr - ferr0, 0);

    cs_low();
    spi_byte(8'h01, rx);
    spi_byte(8'h23, rx);
    spi_byte(8'h5A, rx);
    cs_high();
    exp_q.push_back(16'h235A);
    check_stb("post rst");
    check("post rst addr", addr, 8'h24);

    check("no back-to-back stb", n_dbl, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
